// File: rtl/bus_timer.sv
// 16-bit prescaled interval timer on the 6502 I/O bus, with one-shot/auto-reload modes and an active-low IRQ.
// Optional TIMER_SNAPSHOT_EN: a read of COUNT_L latches COUNT[15:8] so that COUNT_H reads back coherently.
module bus_timer #(
  parameter logic [15:0] PRESCALE_RST = 16'h0000,
  parameter logic [15:0] RELOAD_RST   = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cs,
  input  logic       R_W_n,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_n
);

  logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d, exp_q, exp_d;
  logic [15:0] pcnt_q, pcnt_d, presc_q, presc_d, reload_q, reload_d, count_q, count_d;

  logic wr, wr_ctrl, wr_relh, tick;

  assign wr      = cs & ~R_W_n;
  assign wr_ctrl = wr && (addr_i == 8'h00);
  assign wr_relh = wr && (addr_i == 8'h05);
  // Any CTRL write or RELOAD_H write in this cycle takes precedence over a tick.
  assign tick    = en_q && !wr_ctrl && !wr_relh && (pcnt_q == presc_q);

  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    exp_d    = exp_q;
    pcnt_d   = pcnt_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;

    if (en_q && !wr_ctrl) pcnt_d = tick ? 16'h0000 : pcnt_q + 16'h0001;

    if (tick) begin
      if (count_q != 16'h0000) count_d = count_q - 16'h0001;
      else if (auto_q)         count_d = reload_q;
      else                     en_d    = 1'b0;
    end

    if (wr && (addr_i == 8'h01) && data_i[0]) exp_d = 1'b0;
    // Hardware expiry beats a same-cycle W1C.
    if (tick && (count_q == 16'h0000)) exp_d = 1'b1;

    if (wr) begin
      case (addr_i)
        8'h00: begin
          en_d   = data_i[0];
          auto_d = data_i[1];
          ie_d   = data_i[2];
          if (data_i[0]) pcnt_d = 16'h0000;
        end
        8'h02: presc_d[7:0]   = data_i;
        8'h03: presc_d[15:8]  = data_i;
        8'h04: reload_d[7:0]  = data_i;
        8'h05: begin
          reload_d[15:8] = data_i;
          count_d        = {data_i, reload_q[7:0]};
          pcnt_d         = 16'h0000;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
      pcnt_q   <= 16'h0000;
      presc_q  <= PRESCALE_RST;
      reload_q <= RELOAD_RST;
      count_q  <= RELOAD_RST;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
      pcnt_q   <= pcnt_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [7:0] snap_h_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                               snap_h_q <= RELOAD_RST[15:8];
    else if (cs && R_W_n && addr_i == 8'h06)    snap_h_q <= count_q[15:8];
  end
`endif

  always_comb begin
    data_o = 8'h00;
    if (cs) begin
      case (addr_i)
        8'h00: data_o = {5'b0, ie_q, auto_q, en_q};
        8'h01: data_o = {6'b0, en_q, exp_q};
        8'h02: data_o = presc_q[7:0];
        8'h03: data_o = presc_q[15:8];
        8'h04: data_o = reload_q[7:0];
        8'h05: data_o = reload_q[15:8];
        8'h06: data_o = count_q[7:0];
`ifdef TIMER_SNAPSHOT_EN
        8'h07: data_o = snap_h_q;
`else
        8'h07: data_o = count_q[15:8];
`endif
        default: data_o = 8'h00;
      endcase
    end
  end

  // Driven purely from flops so the bus cannot glitch the IRQ line.
  assign irq_n = ~(exp_q & ie_q);

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: directed scenarios followed by random bus traffic checked against a cycle-level behavioural model.
module tb_bus_timer;

  logic       clk_i = 1'b0;
  logic       rst_n_i, cs, R_W_n;
  logic [7:0] addr_i, data_i, data_o;
  logic       irq_n;

  int checks = 0;
  int passed = 0;

  bit m_en, m_auto, m_ie, m_exp;
  int m_pcnt, m_pre, m_rel, m_cnt, m_snap;

  logic [7:0] v, a, d;
  int         r;

  bus_timer dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .cs     (cs),
    .R_W_n  (R_W_n),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .irq_n  (irq_n)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
    m_pcnt = 0; m_pre = 0; m_rel = 'hFFFF; m_cnt = 'hFFFF; m_snap = 'hFF;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] ad);
    case (ad)
      8'h00: return {5'b0, m_ie, m_auto, m_en};
      8'h01: return {6'b0, m_en, m_exp};
      8'h02: return 8'(m_pre);
      8'h03: return 8'(m_pre >> 8);
      8'h04: return 8'(m_rel);
      8'h05: return 8'(m_rel >> 8);
      8'h06: return 8'(m_cnt);
`ifdef TIMER_SNAPSHOT_EN
      8'h07: return 8'(m_snap);
`else
      8'h07: return 8'(m_cnt >> 8);
`endif
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the timer: advance time first, then let any bus write overrule it.
  task automatic model_edge(input bit c, input bit rw, input logic [7:0] ad, input logic [7:0] dd);
    bit w, set_exp;
    w = c && !rw;
    set_exp = 0;
    if (c && rw && ad == 8'h06) m_snap = m_cnt >> 8;
    if (m_en && !(w && (ad == 8'h00 || ad == 8'h05))) begin
      if (m_pcnt == m_pre) begin
        m_pcnt = 0;
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin
          set_exp = 1;
          if (m_auto) m_cnt = m_rel;
          else        m_en = 0;
        end
      end else m_pcnt = (m_pcnt + 1) % 65536;
    end
    if (w) begin
      case (ad)
        8'h00: begin m_en = dd[0]; m_auto = dd[1]; m_ie = dd[2]; if (dd[0]) m_pcnt = 0; end
        8'h01: if (dd[0]) m_exp = 0;
        8'h02: m_pre = (m_pre & 'hFF00) | int'(dd);
        8'h03: m_pre = (m_pre & 'h00FF) | (int'(dd) * 256);
        8'h04: m_rel = (m_rel & 'hFF00) | int'(dd);
        8'h05: begin m_rel = (m_rel & 'h00FF) | (int'(dd) * 256); m_cnt = m_rel; m_pcnt = 0; end
        default: ;
      endcase
    end
    if (set_exp) m_exp = 1;
  endtask

  // One bus cycle starting just after a rising edge; the read value is sampled before the next edge.
  task automatic bus(input bit c, input bit rw, input logic [7:0] ad, input logic [7:0] dd,
                     output logic [7:0] rv);
    cs = c; R_W_n = rw; addr_i = ad; data_i = dd;
    #1;
    rv = data_o;
    if (c && rw) check($sformatf("rd%02h", ad), 16'(rv), 16'(m_read(ad)));
    else if (!c) check("idle_data", 16'(rv), 16'h0000);
    @(posedge clk_i);
    model_edge(c, rw, ad, dd);
    #1;
    cs = 1'b0; R_W_n = 1'b1;
    check("irq", 16'(irq_n), 16'(!(m_exp && m_ie)));
  endtask

  task automatic wr(input logic [7:0] ad, input logic [7:0] dd);
    logic [7:0] dummy;
    bus(1'b1, 1'b0, ad, dd, dummy);
  endtask

  task automatic rd(input logic [7:0] ad, output logic [7:0] rv);
    bus(1'b1, 1'b1, ad, 8'h00, rv);
  endtask

  task automatic idle(input int n);
    logic [7:0] dummy;
    repeat (n) bus(1'b0, 1'b1, 8'h00, 8'h00, dummy);
  endtask

  initial begin
    cs = 1'b0; R_W_n = 1'b1; addr_i = 8'h00; data_i = 8'h00; rst_n_i = 1'b0;
    model_reset();
    #3;
    check("rst_irq", 16'(irq_n), 16'h0001);
    check("rst_data", 16'(data_o), 16'h0000);
    #9 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset values
    check("t1_irq", 16'(irq_n), 16'h0001);
    check("t1_data", 16'(data_o), 16'h0000);
    rd(8'h04, v); check("t1_rel_l", 16'(v), 16'h00FF);
    rd(8'h05, v); check("t1_rel_h", 16'(v), 16'h00FF);
    rd(8'h00, v); check("t1_ctrl", 16'(v), 16'h0000);

    // Auto-reload, RELOAD=3, PRESCALE=0
    wr(8'h02, 8'h00); wr(8'h03, 8'h00); wr(8'h04, 8'h03); wr(8'h05, 8'h00);
    wr(8'h00, 8'h07);
    rd(8'h06, v); check("t2_cnt_e", 16'(v), 16'h0003);
    rd(8'h06, v); check("t2_cnt_e1", 16'(v), 16'h0002);
    rd(8'h06, v); check("t2_cnt_e2", 16'(v), 16'h0001);
    rd(8'h06, v); check("t2_cnt_e3", 16'(v), 16'h0000);
    check("t2_irq_e4", 16'(irq_n), 16'h0000);
    rd(8'h06, v); check("t2_cnt_e4", 16'(v), 16'h0003);
    wr(8'h01, 8'h01);
    rd(8'h01, v); check("t2_stat_e6", 16'(v), 16'h0002);
    rd(8'h01, v); check("t2_stat_e7", 16'(v), 16'h0002);
    check("t2_irq_e8", 16'(irq_n), 16'h0000);
    rd(8'h01, v); check("t2_stat_e8", 16'(v), 16'h0003);

    // One-shot with PRESCALE=2, RELOAD=1
    wr(8'h00, 8'h00); wr(8'h01, 8'h01);
    wr(8'h02, 8'h02); wr(8'h04, 8'h01); wr(8'h05, 8'h00);
    wr(8'h00, 8'h01);
    idle(5);
    rd(8'h01, v); check("t3_stat_e5", 16'(v), 16'h0002);
    rd(8'h01, v); check("t3_stat_e6", 16'(v), 16'h0001);
    rd(8'h00, v); check("t3_ctrl", 16'(v), 16'h0000);
    rd(8'h06, v); check("t3_cnt_l", 16'(v), 16'h0000);
    rd(8'h07, v); check("t3_cnt_h", 16'(v), 16'h0000);
    check("t3_irq", 16'(irq_n), 16'h0001);

    // Expiry colliding with a W1C of EXP
    wr(8'h01, 8'h01); wr(8'h02, 8'h00); wr(8'h04, 8'h01); wr(8'h05, 8'h00);
    wr(8'h00, 8'h05);
    idle(1);
    wr(8'h01, 8'h01);
    check("t4_irq_race", 16'(irq_n), 16'h0000);
    rd(8'h01, v); check("t4_stat_race", 16'(v), 16'h0001);
    wr(8'h01, 8'h01);
    rd(8'h01, v); check("t4_stat_clr", 16'(v), 16'h0000);
    check("t4_irq_clr", 16'(irq_n), 16'h0001);

    // Coherent 16-bit read across a borrow from 0x0100
    wr(8'h04, 8'h00); wr(8'h05, 8'h01); wr(8'h00, 8'h01);
    rd(8'h06, v); check("t5_cnt_l", 16'(v), 16'h0000);
    rd(8'h07, v);
`ifdef TIMER_SNAPSHOT_EN
    check("t5_snap_h", 16'(v), 16'h0001);
`else
    check("t5_live_h", 16'(v), 16'h0000);
`endif

    // Reset while running with EXP pending and COUNT=0x1234
    wr(8'h00, 8'h00); wr(8'h04, 8'h01); wr(8'h05, 8'h00); wr(8'h00, 8'h07);
    idle(2);
    wr(8'h04, 8'h34); wr(8'h05, 8'h12);
    check("t6_irq_pre", 16'(irq_n), 16'h0000);
    cs = 1'b1; R_W_n = 1'b1; addr_i = 8'h06; #1;
    check("t6_cnt_pre", 16'(data_o), 16'h0034);
    cs = 1'b0;
    rst_n_i = 1'b0; #1;
    check("t6_irq_rst", 16'(irq_n), 16'h0001);
    cs = 1'b1; addr_i = 8'h06; #1; check("t6_cnt_l_rst", 16'(data_o), 16'h00FF);
    addr_i = 8'h07; #1;            check("t6_cnt_h_rst", 16'(data_o), 16'h00FF);
    addr_i = 8'h00; #1;            check("t6_ctrl_rst", 16'(data_o), 16'h0000);
    cs = 1'b0;
    model_reset();
    @(negedge clk_i); rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    rd(8'h00, v); check("t6_ctrl", 16'(v), 16'h0000);
    rd(8'h06, v); check("t6_cnt_l", 16'(v), 16'h00FF);
    rd(8'h07, v); check("t6_cnt_h", 16'(v), 16'h00FF);
    rd(8'h01, v); check("t6_stat", 16'(v), 16'h0000);

    // Random traffic against the model
    repeat (600) begin
      r = $urandom_range(0, 9);
      if (r < 4) idle(1);
      else if (r < 7) begin
        a = ($urandom_range(0, 15) == 0) ? 8'hC3 : 8'($urandom_range(0, 9));
        rd(a, v);
      end else begin
        a = 8'($urandom_range(0, 9));
        case (a)
          8'h00:        d = 8'($urandom_range(0, 7));
          8'h02:        d = 8'($urandom_range(0, 3));
          8'h04:        d = 8'($urandom_range(0, 7));
          8'h03, 8'h05: d = 8'h00;
          default:      d = 8'($urandom_range(0, 255));
        endcase
        wr(a, d);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
